// File: rtl/debounce_pkg.sv
// Purpose: shared constants and elaboration-time helpers for the input debounce bank.
// Latency: none (compile-time only).
// Backpressure: none.
package debounce_pkg;

  // Prescaler counter width; bounds the largest supported CLK_FREQ (MHz).
  localparam int PRESC_W      = 16;
  localparam int CHANNELS_MAX = 64;

  // Ceiling log2, valid for value >= 1 (returns 0 for value == 1).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  function automatic bit channels_ok(input int channels);
    return (channels >= 1) && (channels <= CHANNELS_MAX);
  endfunction

  function automatic bit clk_freq_ok(input int clk_freq);
    return (clk_freq >= 1) && (clk_freq <= (1 << PRESC_W));
  endfunction

  function automatic bit jitter_ok(input int jitter_max);
    return (jitter_max >= 1) && (jitter_max < (1 << 30));
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Purpose: one debounce channel: 2-FF synchroniser, tick-based stability filter, optional edge/event flags.
// Latency: sig_o follows a clean input step after 2 cycles + JITTER_MAX ticks; rise/fall 1 cycle later, event_o 1 more.
// Backpressure: none; free-running, ev_clr is level-sensitive.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int JITTER_MAX = 1000,
  parameter bit INIT_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sig_i,
  input  logic ev_clr,
  output logic sig_o,
  output logic rise,
  output logic fall,
  output logic event_o
);

  localparam int                CNT_W    = clog2(JITTER_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(JITTER_MAX - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             level_q;

  // Two-stage synchroniser for the asynchronous pad input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= INIT_VALUE;
      sync_q2 <= INIT_VALUE;
    end else begin
      sync_q1 <= sig_i;
      sync_q2 <= sync_q1;
    end
  end

  // Accept the synchronised level only after it differs from sig_o for JITTER_MAX ticks in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= INIT_VALUE;
    end else if (sync_q2 == level_q) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        level_q <= sync_q2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sig_o = level_q;

`ifdef DEBOUNCE_EVENT_EN
  logic level_d;
  logic rise_q;
  logic fall_q;
  logic event_q;

  // Registered edge detect; level_d resets to INIT_VALUE so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= INIT_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_d <= level_q;
      rise_q  <= level_q & ~level_d;
      fall_q  <= ~level_q & level_d;
    end
  end

  // Sticky event flag; a new edge beats a simultaneous clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_q <= 1'b0;
    end else if (rise_q || fall_q) begin
      event_q <= 1'b1;
    end else if (ev_clr) begin
      event_q <= 1'b0;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign event_o = event_q;
`else
  logic unused_ev_clr;
  assign unused_ev_clr = ev_clr;
  assign rise          = 1'b0;
  assign fall          = 1'b0;
  assign event_o       = 1'b0;
`endif

endmodule

// File: rtl/input_debounce_bank.sv
// Purpose: CHANNELS-wide switch/button debouncer with one shared 1 us prescaler; edge/event outputs only with DEBOUNCE_EVENT_EN.
// Latency: 2 sync cycles + JITTER_MAX ticks to sig_o; rise/fall +1 cycle; event_o +2 cycles; any_event combinational from event_o.
// Backpressure: none; inputs sampled every cycle, ev_clr takes effect on the next edge.
module input_debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = 21,
  parameter int CLK_FREQ   = 50,
  parameter int JITTER_MAX = 1000,
  parameter bit INIT_VALUE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sig_i,
  input  logic [CHANNELS-1:0] ev_clr,
  output logic [CHANNELS-1:0] sig_o,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] event_o,
  output logic                any_event
);

  // Reject illegal configurations at elaboration.
  if (!channels_ok(CHANNELS)) begin : g_bad_channels
    $error("input_debounce_bank: CHANNELS=%0d outside 1..%0d", CHANNELS, CHANNELS_MAX);
  end
  if (!clk_freq_ok(CLK_FREQ)) begin : g_bad_clk_freq
    $error("input_debounce_bank: CLK_FREQ=%0d outside 1..%0d", CLK_FREQ, 1 << PRESC_W);
  end
  if (!jitter_ok(JITTER_MAX)) begin : g_bad_jitter
    $error("input_debounce_bank: JITTER_MAX=%0d must be at least 1", JITTER_MAX);
  end

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  // With CLK_FREQ == 1 the counter stays at 0 and tick is permanently high.
  assign tick = (presc_cnt == PRESC_LAST);

  // Shared microsecond prescaler: counts 0..CLK_FREQ-1 and wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_ch #(
      .JITTER_MAX (JITTER_MAX),
      .INIT_VALUE (INIT_VALUE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .sig_i   (sig_i[i]),
      .ev_clr  (ev_clr[i]),
      .sig_o   (sig_o[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .event_o (event_o[i])
    );
  end

  assign any_event = |event_o;

endmodule
